// File: rtl/trd_sched.sv
// trd_sched: thread scheduler and PC file for the barrel-threaded core.
// Tracks NUM_TRD hardware threads (FREE/RUN/SLEEP), one PC per thread and the
// parent->child map. Each cycle one RUN thread is picked round-robin after the
// last issued thread and its PC is presented to the instruction port.
//
// Handshake: i_rd is a fetch-valid with no ready; the fetch is accepted at the
// edge unless i_miss, in which case the thread keeps its PC and retries at its
// next turn. vld_dec/trd_dec/pc_dec describe that fetch one cycle later.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall, i_miss                 hold issue / current fetch missed
//   jmp_en, jmp_trd, jmp_pc       EXE redirect
//   d_miss, d_miss_trd, d_miss_pc MEM replay redirect
//   spawn, kill, sleep, wake      WB thread ops (one-hot or none)
//   act_trd, obj_trd, spawn_pc    op issuer (parent), op target, child start PC
//   i_addr, i_rd, trd_if          fetch address / valid / thread
//   trd_dec, pc_dec, vld_dec      registered fetch info for decode
//   flush_id                      kill the decode-stage instruction
//   new_trd_id, trd_full, trd_of  lowest FREE id / none FREE / spawn overflow
//   valid_trd, run_trd, running   per-thread non-FREE / RUN, any non-FREE
//   child                         bit [p*NUM_TRD+c]: c is a child of p
module trd_sched #(
  parameter int          NUM_TRD  = 8,
  parameter int          TRD_W    = $clog2(NUM_TRD),
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       i_miss,
  input  logic                       jmp_en,
  input  logic [TRD_W-1:0]           jmp_trd,
  input  logic [31:0]                jmp_pc,
  input  logic                       d_miss,
  input  logic [TRD_W-1:0]           d_miss_trd,
  input  logic [31:0]                d_miss_pc,
  input  logic                       spawn,
  input  logic                       kill,
  input  logic                       sleep,
  input  logic                       wake,
  input  logic [TRD_W-1:0]           act_trd,
  input  logic [TRD_W-1:0]           obj_trd,
  input  logic [31:0]                spawn_pc,
  output logic [31:0]                i_addr,
  output logic                       i_rd,
  output logic [TRD_W-1:0]           trd_if,
  output logic [TRD_W-1:0]           trd_dec,
  output logic [31:0]                pc_dec,
  output logic                       vld_dec,
  output logic                       flush_id,
  output logic [TRD_W-1:0]           new_trd_id,
  output logic                       trd_full,
  output logic                       trd_of,
  output logic [NUM_TRD-1:0]         valid_trd,
  output logic [NUM_TRD-1:0]         run_trd,
  output logic                       running,
  output logic [NUM_TRD*NUM_TRD-1:0] child
);

  localparam logic [1:0] ST_FREE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_SLEEP = 2'd2;

  logic [1:0]       state [NUM_TRD];
  logic [31:0]      pc    [NUM_TRD];
  logic [TRD_W-1:0] last_trd;

  logic [NUM_TRD-1:0] cand;
  logic [TRD_W-1:0]   pick;
  logic               pick_found;
  logic               issue;
  logic               spawn_ok;
  logic               kill_ok;

  // Thread status vectors. A thread being redirected, killed or put to sleep
  // this cycle is not a fetch candidate: its PC is about to change or it is
  // about to stop.
  always_comb begin
    for (int t = 0; t < NUM_TRD; t++) begin
      valid_trd[t] = (state[t] != ST_FREE);
      run_trd[t]   = (state[t] == ST_RUN);
      cand[t]      = run_trd[t]
                     & ~(jmp_en & (jmp_trd == TRD_W'(t)))
                     & ~(d_miss & (d_miss_trd == TRD_W'(t)))
                     & ~((kill | sleep) & (obj_trd == TRD_W'(t)));
    end
  end

  // Round-robin pick: scan last_trd+1 .. last_trd+NUM_TRD; the id width wraps
  // naturally because NUM_TRD is a power of two.
  always_comb begin
    pick       = last_trd;
    pick_found = 1'b0;
    for (int i = 1; i <= NUM_TRD; i++) begin
      if (!pick_found && cand[last_trd + TRD_W'(i)]) begin
        pick       = last_trd + TRD_W'(i);
        pick_found = 1'b1;
      end
    end
  end

  // Lowest FREE id: scan downward so the lowest match is written last.
  always_comb begin
    new_trd_id = '0;
    for (int t = NUM_TRD - 1; t >= 0; t--) begin
      if (!valid_trd[t]) new_trd_id = TRD_W'(t);
    end
  end

  assign trd_full = &valid_trd;
  assign running  = |valid_trd;
  assign i_rd     = ~stall & pick_found;
  assign i_addr   = pc[pick];
  assign trd_if   = pick;
  assign issue    = i_rd & ~i_miss;
  assign spawn_ok = spawn & ~trd_full;
  assign kill_ok  = kill & valid_trd[obj_trd];

  assign flush_id = vld_dec & ((jmp_en & (jmp_trd == trd_dec)) |
                               (d_miss & (d_miss_trd == trd_dec)) |
                               (kill & (obj_trd == trd_dec)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_TRD; t++) begin
        state[t] <= (t == 0) ? ST_RUN : ST_FREE;
        pc[t]    <= (t == 0) ? RESET_PC : 32'h0;
      end
      last_trd <= TRD_W'(NUM_TRD - 1);
      child    <= '0;
      trd_dec  <= '0;
      pc_dec   <= '0;
      vld_dec  <= 1'b0;
      trd_of   <= 1'b0;
    end else begin
      trd_dec <= trd_if;
      pc_dec  <= i_addr;
      vld_dec <= issue;
      trd_of  <= spawn & trd_full;
      // The pointer moves on a missed fetch too, so other threads get a turn
      // before the missing one retries.
      if (i_rd) last_trd <= pick;

      for (int t = 0; t < NUM_TRD; t++) begin
        if (kill_ok && obj_trd == TRD_W'(t)) begin
          state[t] <= ST_FREE;
        end else if (spawn_ok && new_trd_id == TRD_W'(t)) begin
          state[t] <= ST_RUN;
          pc[t]    <= spawn_pc;
        end else begin
          if (d_miss && d_miss_trd == TRD_W'(t))
            pc[t] <= d_miss_pc;
          else if (jmp_en && jmp_trd == TRD_W'(t))
            pc[t] <= jmp_pc;
          else if (issue && pick == TRD_W'(t))
            pc[t] <= pc[t] + 32'd4;

          if (sleep && obj_trd == TRD_W'(t) && state[t] == ST_RUN)
            state[t] <= ST_SLEEP;
          else if (wake && obj_trd == TRD_W'(t) && state[t] == ST_SLEEP)
            state[t] <= ST_RUN;
        end
      end

      // Killing T drops both its own children links and its link to its parent.
      for (int p = 0; p < NUM_TRD; p++) begin
        for (int c = 0; c < NUM_TRD; c++) begin
          if (kill_ok && (obj_trd == TRD_W'(p) || obj_trd == TRD_W'(c)))
            child[p*NUM_TRD+c] <= 1'b0;
          else if (spawn_ok && act_trd == TRD_W'(p) && new_trd_id == TRD_W'(c))
            child[p*NUM_TRD+c] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/trd_sched.md
# trd_sched

Parametrised thread scheduler and PC file for the barrel-threaded ThreadKraken core. It generalises the 8-thread instruction-fetch control to `NUM_TRD` hardware threads. Per thread it holds a state (FREE/RUN/SLEEP) and a PC. Each cycle it issues one fetch in round-robin order and handles redirects and thread spawn/kill/sleep/wake. It also keeps the parent→child map. It sits between the MMU instruction port and decode, and is driven by EXE (jumps), MEM (data-miss replay) and WB (thread ops).

## Interface
Parameters:
- `NUM_TRD`, default 8: number of hardware threads, ≥2, power of two.
- `TRD_W`, default `$clog2(NUM_TRD)`: thread-id width.
- `RESET_PC`, default 32'h0: start PC of thread 0.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold issue; no PC/pointer update.
- `i_miss`  in  1  current fetch missed; retry later.
- `jmp_en`  in  1  EXE redirect valid.
- `jmp_trd`  in  TRD_W  thread being redirected.
- `jmp_pc`  in  32  redirect target.
- `d_miss`  in  1  MEM data miss; replay the instruction.
- `d_miss_trd`  in  TRD_W  thread that missed.
- `d_miss_pc`  in  32  PC of the missing instruction.
- `spawn`, `kill`, `sleep`, `wake`  in  1 each  WB thread ops, at most one per cycle.
- `act_trd`  in  TRD_W  thread executing the op (the parent, for spawn).
- `obj_trd`  in  TRD_W  target of kill/sleep/wake.
- `spawn_pc`  in  32  start PC of the new thread.
- `i_addr`  out  32  fetch address.
- `i_rd`  out  1  fetch valid.
- `trd_if`  out  TRD_W  thread being fetched.
- `trd_dec`  out  TRD_W  registered `trd_if`.
- `pc_dec`  out  32  registered PC of that fetch.
- `vld_dec`  out  1  registered `i_rd & ~i_miss`.
- `flush_id`  out  1  kill the decode-stage instruction.
- `new_trd_id`  out  TRD_W  lowest FREE thread id.
- `trd_full`  out  1  no FREE thread.
- `trd_of`  out  1  one-cycle pulse: spawn attempted while full.
- `valid_trd`  out  NUM_TRD  thread is not FREE.
- `run_trd`  out  NUM_TRD  thread is RUN.
- `running`  out  1  `|valid_trd`.
- `child`  out  NUM_TRD*NUM_TRD  bit [p*NUM_TRD+c] set: c is a child of p.

## Operation
- Per-thread state: FREE, RUN, SLEEP.
- State transitions:
  - spawn: FREE→RUN.
  - sleep: RUN→SLEEP.
  - wake: SLEEP→RUN.
  - kill: any state→FREE.
  - Any op on a FREE target is ignored. Wake of a RUN thread is ignored.
- Pick: the first RUN thread after `last_trd` (wrapping NUM_TRD-1→0), excluding threads redirected, killed or slept this cycle.
  - `i_rd = ~stall & pick_found`.
  - `i_addr = pc[pick]`, `trd_if = pick`, both combinational from registers.
- PC update priority per thread at an edge: kill > d_miss (pc←`d_miss_pc`) > jmp (pc←`jmp_pc`) > issue (pc←pc+4 if `i_rd & ~i_miss`).
- `last_trd` updates to pick only when `i_rd`, including on `i_miss`. The missing thread keeps its PC and retries at its next turn.
- Spawn: `new_trd_id` ← state RUN, pc←`spawn_pc`, `child[act_trd][new]`←1.
  - If `trd_full`: no state change, `trd_of` pulses the next cycle.
- Kill of T: clear row T and column T of `child`. Children of T keep running.
- `flush_id = vld_dec & ((jmp_en & jmp_trd==trd_dec) | (d_miss & d_miss_trd==trd_dec) | (kill & obj_trd==trd_dec))`.
- Sleep is lazy: instructions already issued by the thread complete.

## Timing
- Reset values:
  - Thread 0 is RUN with pc=`RESET_PC`; all other threads are FREE with pc=0.
  - `last_trd` = NUM_TRD-1, so thread 0 is picked first.
  - `child`=0; `trd_dec`, `pc_dec`, `vld_dec`, `trd_of` = 0.
  - `valid_trd`=1, `run_trd`=1, `running`=1, `trd_full`=0, `new_trd_id`=1.
  - `i_rd`=1 in the first cycle after reset, unless `stall`.
- Fetch→decode latency is 1 cycle. `i_rd_data` pairs with `trd_dec`/`pc_dec` on the following cycle.
- Thread ops, redirects and spawn take effect at the edge. A spawned thread is eligible for pick in the next cycle.
- Reset asserted mid-operation discards all threads and map bits within the same edge.
- Simultaneous `d_miss` and `jmp_en` on the same thread: `d_miss` wins.
- Simultaneous events on different threads are each applied.

## Test plan
- Reset release, no stall, no misses → `i_addr` = 0,4,8,… on thread 0; `run_trd`=8'h01; `new_trd_id`=1.
- Thread 0 spawns with `spawn_pc`=0x100, then spawns 0x200 → `run_trd`=8'h07; fetches alternate 0→1→2→0 with PCs 0x100/0x200 advancing by 4; `child[0*8+1]` and `child[0*8+2]` set.
- Fill all 8 threads, then spawn again → `trd_full`=1, `trd_of` high for exactly 1 cycle, `valid_trd` unchanged.
- `i_miss` on thread 1 at pc 0x104 → `vld_dec`=0; thread 1's next fetch is again 0x104.
- Same cycle: `jmp_en` (thread 2, 0x400), `d_miss` (thread 2, 0x220) and `trd_dec`=2 → `flush_id`=1; thread 2's next fetch is 0x220.
- Sleep 1 then wake 1 → thread 1 is skipped in rotation while asleep and resumes at its held PC. Kill 1 → column 1 of `child` is cleared and `new_trd_id`=1.
